led_step_counter: RTL

Parametrised successor to the board's free-running 8-bit LED counter. It adds:
- a configurable width and modulus;
- an integrated prescaler, so a fast PLL clock can drive human-visible LED rates;
- synchronous clear and load;
- up/down direction and wrap/saturate mode;
- a terminal-count pulse.

It sits between the PLL-derived system clock and the LED outputs in the board tops, and can also serve as a general event counter.

---
 rtl/counter_pkg.sv | 21 ++
 rtl/prescale_tick.sv | 46 ++++
 rtl/led_step_counter.sv | 91 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared counter definitions: saturation-mode encodings and a clog2 helper used to size
// the prescaler register.
package counter_pkg;

  localparam int unsigned CNT_WRAP = 0;
  localparam int unsigned CNT_SAT  = 1;

  // Bits needed to hold values 0..v-1; returns 0 for v <= 1.
  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned bits;
    longint unsigned rem;
    bits = 0;
    rem  = (v > 0) ? v - 1 : 0;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/prescale_tick.sv
// Enable-gated prescaler: emits a single-cycle tick every PRESCALE enabled cycles.
module prescale_tick
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned PreW = (clog2(PRESCALE) > 1) ? clog2(PRESCALE) : 1;

  if (PRESCALE <= 1) begin : g_bypass
    logic unused_inputs;
    assign unused_inputs = clk ^ rst_n ^ clr_i;
    assign tick_o = en_i;
  end else begin : g_count
    localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

    logic [PreW-1:0] pre_q, pre_d;

    assign tick_o = en_i && (pre_q == PreLast);

    // Disabled cycles freeze the phase rather than restarting it.
    always_comb begin
      pre_d = pre_q;
      if (clr_i) begin
        pre_d = '0;
      end else if (en_i) begin
        pre_d = tick_o ? '0 : pre_q + PreW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_d;
      end
    end
  end

endmodule

// File: rtl/led_step_counter.sv
// Prescaled up/down counter with clear, clamped load, wrap/saturate boundary handling and
// registered step / terminal-count pulses.
module led_step_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter int unsigned     PRESCALE = 1,
  parameter int unsigned     SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] q_o,
  output logic             step_o,
  output logic             tc_o
);

  localparam int unsigned W1 = WIDTH + 1;
  // One extra bit so MODULUS-1 and clamp comparisons never overflow at MODULUS=2**WIDTH.
  localparam logic [W1-1:0] MaxExt = W1'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MaxVal = MaxExt[WIDTH-1:0];

  logic             tick;
  logic [WIDTH-1:0] q_q, q_d;
  logic             step_q, step_d;
  logic             tc_q, tc_d;
  logic [W1-1:0]    q_ext, load_ext;

  prescale_tick #(
    .PRESCALE(PRESCALE)
  ) u_prescale (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clear_i | load_i),
    .en_i  (en_i),
    .tick_o(tick)
  );

  assign q_ext    = {1'b0, q_q};
  assign load_ext = {1'b0, load_val_i};

  always_comb begin
    q_d    = q_q;
    step_d = 1'b0;
    tc_d   = 1'b0;
    if (clear_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = (load_ext > MaxExt) ? MaxVal : load_val_i;
    end else if (tick) begin
      step_d = 1'b1;
      if (up_i) begin
        if (q_ext == MaxExt) begin
          tc_d = 1'b1;
          if (SATURATE == CNT_WRAP) q_d = '0;
        end else begin
          q_d = WIDTH'(q_ext + W1'(1));
        end
      end else begin
        if (q_q == '0) begin
          tc_d = 1'b1;
          if (SATURATE == CNT_WRAP) q_d = MaxVal;
        end else begin
          q_d = WIDTH'(q_ext - W1'(1));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      step_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      step_q <= step_d;
      tc_q   <= tc_d;
    end
  end

  assign q_o    = q_q;
  assign step_o = step_q;
  assign tc_o   = tc_q;

endmodule
